// File: rtl/if_fetch_stage.sv
// PC register and IF/ID pipeline register for the 5-stage MIPS pipeline.
// Handles stall/flush priority, saturating perf counters and a sticky misalignment flag.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC_i,
  input  logic             stall,
  input  logic             jump_flush,
  input  logic             branch_flush,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      PC_o,
  output logic [31:0]      if_id_reg_PC_Plus_4,
  output logic [31:0]      if_id_reg_Inst,
  output logic             if_id_valid,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count,
  output logic             pc_misalign
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ACT_FETCH  = 2'd0;
  localparam logic [1:0] ACT_HOLD   = 2'd1;
  localparam logic [1:0] ACT_JUMP   = 2'd2;
  localparam logic [1:0] ACT_BRANCH = 2'd3;

  logic [1:0]  act_c;
  logic [31:0] pc_aligned_c;
  logic [31:0] pc_plus_4_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Priority decode: branch_flush > stall > jump_flush > normal fetch
  always_comb begin
    act_c = ACT_FETCH;
    if (branch_flush)    act_c = ACT_BRANCH;
    else if (stall)      act_c = ACT_HOLD;
    else if (jump_flush) act_c = ACT_JUMP;
  end

  assign pc_aligned_c = {PC_i[31:2], 2'b00};
  assign pc_plus_4_c  = PC_o + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_o                <= RESET_PC;
      if_id_reg_PC_Plus_4 <= 32'd0;
      if_id_reg_Inst      <= 32'd0;
      if_id_valid         <= 1'b0;
      id_ex_flush         <= 1'b0;
      fetch_count         <= '0;
      stall_count         <= '0;
      bubble_count        <= '0;
      pc_misalign         <= 1'b0;
    end else begin
      id_ex_flush <= (act_c == ACT_BRANCH);
      // Every non-holding edge loads the PC and checks the low bits of the new value
      if (act_c != ACT_HOLD) begin
        PC_o <= pc_aligned_c;
        if (PC_i[1:0] != 2'b00) pc_misalign <= 1'b1;
      end
      case (act_c)
        ACT_BRANCH, ACT_JUMP: begin
          if_id_reg_PC_Plus_4 <= 32'd0;
          if_id_reg_Inst      <= 32'd0;
          if_id_valid         <= 1'b0;
          bubble_count        <= sat_inc(bubble_count);
        end
        ACT_HOLD: begin
          stall_count <= sat_inc(stall_count);
        end
        default: begin
          if_id_reg_PC_Plus_4 <= pc_plus_4_c;
          if_id_reg_Inst      <= imem_rdata;
          if_id_valid         <= 1'b1;
          fetch_count         <= sat_inc(fetch_count);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run against
// a behavioural model of the fetch-stage rules (CNT_W=4 to reach saturation quickly).
module tb_if_fetch_stage;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX_I = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      PC_i = 32'd0;
  logic             stall = 1'b0;
  logic             jump_flush = 1'b0;
  logic             branch_flush = 1'b0;
  logic [31:0]      imem_rdata = 32'd0;
  logic [31:0]      PC_o;
  logic [31:0]      if_id_reg_PC_Plus_4;
  logic [31:0]      if_id_reg_Inst;
  logic             if_id_valid;
  logic             id_ex_flush;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] bubble_count;
  logic             pc_misalign;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state
  logic [31:0] m_pc, m_p4, m_inst;
  logic        m_valid, m_flush, m_mis;
  int          m_fc, m_sc, m_bc;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PC_i(PC_i), .stall(stall),
    .jump_flush(jump_flush), .branch_flush(branch_flush), .imem_rdata(imem_rdata),
    .PC_o(PC_o), .if_id_reg_PC_Plus_4(if_id_reg_PC_Plus_4), .if_id_reg_Inst(if_id_reg_Inst),
    .if_id_valid(if_id_valid), .id_ex_flush(id_ex_flush), .fetch_count(fetch_count),
    .stall_count(stall_count), .bubble_count(bubble_count), .pc_misalign(pc_misalign)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= CNT_MAX_I) ? CNT_MAX_I : v + 1;
  endfunction

  function automatic void model_load(input logic [31:0] pci);
    if (pci % 4 != 0) m_mis = 1'b1;
    m_pc = pci - (pci % 4);
  endfunction

  // Drive one edge's inputs, clock, update the reference, settle 1ns past the edge
  task automatic step(input logic [31:0] pci, input logic st, input logic jf,
                      input logic bf, input logic rst, input logic [31:0] rd);
    PC_i = pci; stall = st; jump_flush = jf; branch_flush = bf; reset = rst; imem_rdata = rd;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'd0; m_p4 = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_flush = 1'b0;
      m_mis = 1'b0; m_fc = 0; m_sc = 0; m_bc = 0;
    end else if (bf) begin
      model_load(pci);
      m_p4 = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_flush = 1'b1; m_bc = sat(m_bc);
    end else if (st) begin
      m_flush = 1'b0; m_sc = sat(m_sc);
    end else if (jf) begin
      model_load(pci);
      m_p4 = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_flush = 1'b0; m_bc = sat(m_bc);
    end else begin
      m_p4 = m_pc + 32'd4; m_inst = rd; m_valid = 1'b1;
      model_load(pci);
      m_flush = 1'b0; m_fc = sat(m_fc);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    step(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    n_cmp++;
    if ({PC_o, if_id_reg_PC_Plus_4, if_id_reg_Inst} !== 96'd0) begin
      n_fail++; $display("FAIL reset_regs: got %h %h %h required 0 0 0", PC_o, if_id_reg_PC_Plus_4, if_id_reg_Inst);
    end
    n_cmp++;
    if ({if_id_valid, id_ex_flush, pc_misalign, fetch_count, stall_count, bubble_count} !== '0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b flush=%b mis=%b fc=%h sc=%h bc=%h required all 0",
                         if_id_valid, id_ex_flush, pc_misalign, fetch_count, stall_count, bubble_count);
    end
  endtask

  task automatic test_normal;
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exp_in [3] = '{32'h2008_0001, 32'h2008_0002, 32'h2008_0003};
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(PC_o + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, exp_in[i]);
      n_cmp++;
      if (PC_o !== exp_pc[i] || if_id_reg_Inst !== exp_in[i] || if_id_reg_PC_Plus_4 !== exp_pc[i] || if_id_valid !== 1'b1) begin
        n_fail++; $display("FAIL normal_fetch[%0d]: pc=%h inst=%h p4=%h v=%b required pc=%h inst=%h p4=%h v=1",
                           i, PC_o, if_id_reg_Inst, if_id_reg_PC_Plus_4, if_id_valid, exp_pc[i], exp_in[i], exp_pc[i]);
      end
    end
    n_cmp++;
    if (fetch_count !== 4'd3) begin
      n_fail++; $display("FAIL normal_fetch_count: got %0d required 3", fetch_count);
    end
  endtask

  task automatic test_stall;
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0001);
    step(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0002);
    // Misaligned PC_i while holding must not be evaluated
    step(32'h0000_0123, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    step(32'h0000_0123, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    n_cmp++;
    if (PC_o !== 32'h8 || if_id_reg_Inst !== 32'h2008_0002 || if_id_reg_PC_Plus_4 !== 32'h8 || if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: pc=%h inst=%h p4=%h v=%b required pc=8 inst=20080002 p4=8 v=1",
                         PC_o, if_id_reg_Inst, if_id_reg_PC_Plus_4, if_id_valid);
    end
    n_cmp++;
    if (stall_count !== 4'd2 || pc_misalign !== 1'b0 || fetch_count !== 4'd2) begin
      n_fail++; $display("FAIL stall_counts: sc=%0d mis=%b fc=%0d required sc=2 mis=0 fc=2", stall_count, pc_misalign, fetch_count);
    end
    step(32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2008_0003);
    n_cmp++;
    if (PC_o !== 32'hC || if_id_reg_Inst !== 32'h2008_0003 || if_id_reg_PC_Plus_4 !== 32'hC) begin
      n_fail++; $display("FAIL stall_release: pc=%h inst=%h p4=%h required pc=c inst=20080003 p4=c",
                         PC_o, if_id_reg_Inst, if_id_reg_PC_Plus_4);
    end
  endtask

  task automatic test_jump;
    step(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2008_0004);
    n_cmp++;
    if (PC_o !== 32'h40 || if_id_reg_Inst !== 32'h0 || if_id_reg_PC_Plus_4 !== 32'h0 || if_id_valid !== 1'b0 || id_ex_flush !== 1'b0) begin
      n_fail++; $display("FAIL jump_flush: pc=%h inst=%h p4=%h v=%b fl=%b required pc=40 inst=0 p4=0 v=0 fl=0",
                         PC_o, if_id_reg_Inst, if_id_reg_PC_Plus_4, if_id_valid, id_ex_flush);
    end
    n_cmp++;
    if (bubble_count !== 4'd1) begin
      n_fail++; $display("FAIL jump_bubble_count: got %0d required 1", bubble_count);
    end
  endtask

  task automatic test_branch;
    step(32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111_1111);
    step(32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2222_2222);
    n_cmp++;
    if (PC_o !== 32'h100 || if_id_valid !== 1'b0 || if_id_reg_Inst !== 32'h0 || id_ex_flush !== 1'b1) begin
      n_fail++; $display("FAIL branch_flush: pc=%h v=%b inst=%h fl=%b required pc=100 v=0 inst=0 fl=1",
                         PC_o, if_id_valid, if_id_reg_Inst, id_ex_flush);
    end
    n_cmp++;
    if (stall_count !== CNT_W'(m_sc) || stall_count !== 4'd2 || bubble_count !== 4'd2) begin
      n_fail++; $display("FAIL branch_counts: sc=%0d bc=%0d required sc=2 bc=2", stall_count, bubble_count);
    end
    step(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3333_3333);
    n_cmp++;
    if (id_ex_flush !== 1'b0 || PC_o !== 32'h104 || if_id_reg_Inst !== 32'h3333_3333 || if_id_reg_PC_Plus_4 !== 32'h104) begin
      n_fail++; $display("FAIL branch_after: fl=%b pc=%h inst=%h p4=%h required fl=0 pc=104 inst=33333333 p4=104",
                         id_ex_flush, PC_o, if_id_reg_Inst, if_id_reg_PC_Plus_4);
    end
    step(32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4444_4444);
    n_cmp++;
    if (PC_o !== 32'h104 || if_id_valid !== 1'b1 || if_id_reg_Inst !== 32'h3333_3333 || bubble_count !== 4'd2 || stall_count !== 4'd3) begin
      n_fail++; $display("FAIL stall_over_jump: pc=%h v=%b inst=%h bc=%0d sc=%0d required pc=104 v=1 inst=33333333 bc=2 sc=3",
                         PC_o, if_id_valid, if_id_reg_Inst, bubble_count, stall_count);
    end
    // Back-to-back branch flushes each count a bubble
    step(32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(32'h400, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (bubble_count !== 4'd4 || id_ex_flush !== 1'b1 || PC_o !== 32'h400) begin
      n_fail++; $display("FAIL back_to_back: bc=%0d fl=%b pc=%h required bc=4 fl=1 pc=400", bubble_count, id_ex_flush, PC_o);
    end
  endtask

  task automatic test_misalign_wrap;
    step(32'h0000_0046, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (PC_o !== 32'h44 || pc_misalign !== 1'b1) begin
      n_fail++; $display("FAIL misalign_set: pc=%h mis=%b required pc=44 mis=1", PC_o, pc_misalign);
    end
    step(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
    n_cmp++;
    if (pc_misalign !== 1'b1 || if_id_reg_PC_Plus_4 !== 32'h0 || if_id_reg_Inst !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL misalign_sticky_wrap: mis=%b p4=%h inst=%h required mis=1 p4=0 inst=5555aaaa",
                         pc_misalign, if_id_reg_PC_Plus_4, if_id_reg_Inst);
    end
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    n_cmp++;
    if (pc_misalign !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clear: got %b required 0", pc_misalign);
    end
  endtask

  task automatic test_saturation_reset;
    for (int i = 0; i < 18; i++) step(PC_o + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    n_cmp++;
    if (fetch_count !== 4'hF) begin
      n_fail++; $display("FAIL fetch_saturate: got %h required f", fetch_count);
    end
    step(32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(32'h8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    n_cmp++;
    if ({PC_o, if_id_reg_PC_Plus_4, if_id_reg_Inst, if_id_valid, id_ex_flush, pc_misalign,
         fetch_count, stall_count, bubble_count} !== '0) begin
      n_fail++; $display("FAIL reset_mid_stall: pc=%h p4=%h inst=%h v=%b fl=%b fc=%h sc=%h bc=%h required all 0",
                         PC_o, if_id_reg_PC_Plus_4, if_id_reg_Inst, if_id_valid, id_ex_flush,
                         fetch_count, stall_count, bubble_count);
    end
  endtask

  task automatic test_random;
    logic [31:0] pci;
    for (int i = 0; i < 400; i++) begin
      pci = $urandom;
      if ($urandom_range(0, 7) != 0) pci[1:0] = 2'b00;
      step(pci, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 79) == 0, $urandom);
      n_cmp++;
      if (PC_o !== m_pc || if_id_reg_PC_Plus_4 !== m_p4 || if_id_reg_Inst !== m_inst || if_id_valid !== m_valid) begin
        n_fail++; $display("FAIL rand_pipe[%0d]: pc=%h p4=%h inst=%h v=%b required pc=%h p4=%h inst=%h v=%b",
                           i, PC_o, if_id_reg_PC_Plus_4, if_id_reg_Inst, if_id_valid, m_pc, m_p4, m_inst, m_valid);
      end
      n_cmp++;
      if (id_ex_flush !== m_flush || pc_misalign !== m_mis || fetch_count !== CNT_W'(m_fc) ||
          stall_count !== CNT_W'(m_sc) || bubble_count !== CNT_W'(m_bc)) begin
        n_fail++; $display("FAIL rand_status[%0d]: fl=%b mis=%b fc=%0d sc=%0d bc=%0d required fl=%b mis=%b fc=%0d sc=%0d bc=%0d",
                           i, id_ex_flush, pc_misalign, fetch_count, stall_count, bubble_count,
                           m_flush, m_mis, m_fc, m_sc, m_bc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_jump();
    test_branch();
    test_misalign_wrap();
    test_saturation_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
